adc_sdram_reader: RTL and testbench

- Avalon-MM read master that fetches a block of captured ADC samples back out of SDRAM and presents them on a valid/ready stream for the host link (UART/USB framer).
- Counterpart of the ADC-to-SDRAM write master: it shares the SDRAM port signal set and reads the same address space that master fills.
- Supports pipelined reads with a bounded number of outstanding requests. An internal FIFO absorbs read latency so downstream backpressure never loses data.

---
 rtl/adc_sdram_reader.sv | 197 +++++++++++++++++++
 tb/tb_adc_sdram_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sdram_reader.sv
// Avalon-MM read master: fetches a block of ADC samples from SDRAM and streams them out through a FIFO.
// Optional running checksum of the streamed words: define ADC_SDRAM_READER_CHECKSUM_EN.
module adc_sdram_reader #(
    parameter int ADDR_W      = 24,
    parameter int CNT_W       = 23,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic              sdram_read_n,
    input  logic [15:0]       sdram_readdata,
    input  logic              sdram_readdatavalid,
    input  logic              sdram_waitrequest,
    output logic [15:0]       data_out,
    output logic              data_valid,
    input  logic              data_ready
`ifdef ADC_SDRAM_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int SUM_W  = ((LVL_W > PEND_W) ? LVL_W : PEND_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  delivered;
    logic [PEND_W-1:0] pending;
    logic [LVL_W-1:0]  level;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [SUM_W-1:0]  credit_sum;

    logic credit_ok;
    logic read_req;
    logic req_accept;
    logic rsp_accept;
    logic pop;
    logic start_accept;

    // Every outstanding read already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_sum = SUM_W'(pending) + SUM_W'(level);
    assign credit_ok  = (credit_sum < SUM_W'(FIFO_DEPTH)) && (pending < PEND_W'(MAX_PENDING));

    assign start_accept = (state == IDLE) && start;
    assign req_accept   = read_req && !sdram_waitrequest;
    assign rsp_accept   = sdram_readdatavalid && (state == ISSUE || state == DRAIN) && (pending != '0);
    assign pop          = data_valid && data_ready;

    assign sdram_read_n       = ~read_req;
    assign sdram_byteenable_n = 2'b00;
    assign sdram_chipselect   = 1'b1;

    assign data_valid = (level != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read_req   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                read_req = (issued < count) && credit_ok;
                if (read_req && !sdram_waitrequest && (issued == count - 1'b1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pending == '0 && level == '0 && delivered == count) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_addr <= '0;
            count      <= '0;
            issued     <= '0;
            delivered  <= '0;
        end else begin
            if (start_accept) begin
                sdram_addr <= base_addr;
                count      <= word_count;
                issued     <= '0;
            end else if (req_accept) begin
                sdram_addr <= sdram_addr + 1'b1;
                issued     <= issued + 1'b1;
            end

            if (start_accept) begin
                delivered <= '0;
            end else if (pop) begin
                delivered <= delivered + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({req_accept, rsp_accept})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // First-word fall-through FIFO; storage is not reset, only the pointers.
    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            mem[wr_ptr] <= sdram_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (rsp_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({rsp_accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef ADC_SDRAM_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= 16'h0000;
        end else if (start_accept) begin
            checksum <= 16'h0000;
        end else if (pop) begin
            checksum <= checksum + data_out;
        end
    end
`endif

endmodule

// File: tb/tb_adc_sdram_reader.sv
// Directed self-checking bench for adc_sdram_reader with a latency-programmable SDRAM read model.
// Checksum check is included when ADC_SDRAM_READER_CHECKSUM_EN is defined.
module tb_adc_sdram_reader;

    localparam int ADDR_W      = 24;
    localparam int CNT_W       = 23;
    localparam int FIFO_DEPTH  = 16;
    localparam int MAX_PENDING = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sdram_addr;
    logic [1:0]        sdram_byteenable_n;
    logic              sdram_chipselect;
    logic              sdram_read_n;
    logic [15:0]       sdram_readdata;
    logic              sdram_readdatavalid;
    logic              sdram_waitrequest;
    logic [15:0]       data_out;
    logic              data_valid;
    logic              data_ready;
`ifdef ADC_SDRAM_READER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    adc_sdram_reader #(
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .sdram_addr(sdram_addr),
        .sdram_byteenable_n(sdram_byteenable_n),
        .sdram_chipselect(sdram_chipselect),
        .sdram_read_n(sdram_read_n),
        .sdram_readdata(sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest(sdram_waitrequest),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready)
`ifdef ADC_SDRAM_READER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    rsp_t              rspQ[$];
    logic [ADDR_W-1:0] accAddr[$];
    logic [15:0]       rx[$];

    int cyc;
    int latency;
    int readyMode;
    int stallIndex;
    int stallLeft;
    int stallCycles;
    int holdErr;
    bit stallStarted;
    logic [ADDR_W-1:0] stallAddr;
    int accCount, retCount, popCount;
    int doneCount, doneCycle, busyCycles, readLowCycles, validCycles;
    int maxOut, maxLvl, creditErr;
    int firstAcc, firstValid, startCycle;
    logic doneBusy;
    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive the slave/sink for this cycle, observe the DUT, then move to the next negedge.
    task automatic applyStimulus();
        rsp_t r;
        int   outst;
        int   lvl;
        sdram_readdatavalid = 1'b0;
        sdram_readdata      = 16'h0000;
        if (rspQ.size() > 0 && rspQ[0].due <= cyc) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = rspQ[0].data;
            void'(rspQ.pop_front());
        end

        sdram_waitrequest = 1'b0;
        if (stallLeft > 0 && accCount == stallIndex && (stallStarted || !sdram_read_n)) begin
            if (sdram_read_n || sdram_addr !== stallAddr) holdErr++;
            sdram_waitrequest = 1'b1;
            stallStarted      = 1'b1;
            stallLeft--;
            stallCycles++;
        end

        case (readyMode)
            1:       data_ready = (cyc % 4 == 0);
            2:       data_ready = 1'b0;
            default: data_ready = 1'b1;
        endcase

        outst = accCount - retCount;
        lvl   = retCount - popCount;
        if (outst > maxOut) maxOut = outst;
        if (lvl > maxLvl) maxLvl = lvl;
        if (!sdram_read_n) begin
            readLowCycles++;
            if (outst >= MAX_PENDING || outst + lvl >= FIFO_DEPTH) creditErr++;
        end
        if (!sdram_read_n && !sdram_waitrequest) begin
            accAddr.push_back(sdram_addr);
            r.due  = cyc + latency;
            r.data = sdram_addr[15:0];
            rspQ.push_back(r);
            if (firstAcc < 0) firstAcc = cyc;
            accCount++;
        end
        if (sdram_readdatavalid) retCount++;
        if (data_valid) begin
            validCycles++;
            if (firstValid < 0) firstValid = cyc;
        end
        if (data_valid && data_ready) begin
            rx.push_back(data_out);
            popCount++;
        end
        if (done) begin
            doneCount++;
            doneCycle = cyc;
            doneBusy  = busy;
        end
        if (busy) busyCycles++;

        @(negedge clk);
        cyc++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic clearStats();
        accAddr.delete();
        rx.delete();
        accCount = 0; retCount = 0; popCount = 0;
        doneCount = 0; doneCycle = -1; busyCycles = 0; readLowCycles = 0; validCycles = 0;
        maxOut = 0; maxLvl = 0; creditErr = 0;
        firstAcc = -1; firstValid = -1;
        stallCycles = 0; holdErr = 0; stallStarted = 1'b0;
        doneBusy = 1'b1;
    endtask

    task automatic startTransfer(input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] cnt);
        int guard;
        guard = 0;
        while (rspQ.size() > 0 && guard < 100) begin
            applyStimulus();
            guard++;
        end
        clearStats();
        base_addr  = addr;
        word_count = cnt;
        start      = 1'b1;
        startCycle = cyc;
        applyStimulus();
        start = 1'b0;
    endtask

    task automatic runUntilDone(input string tag, input int budget);
        int n;
        n = 0;
        while (doneCount == 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        if (doneCount == 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        runCycles(3);
    endtask

    task automatic checkWords(input string tag, input logic [15:0] first, input int n);
        logic [15:0] expWord;
        logic [31:0] got;
        checkOutput({tag, "_count"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            expWord = first + 16'(i);
            got     = (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s_word%0d", tag, i), got, 32'(expWord));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_read_n"}, 32'(sdram_read_n), 32'd1);
        checkOutput({tag, "_addr"}, 32'(sdram_addr), 32'd0);
        checkOutput({tag, "_valid"}, 32'(data_valid), 32'd0);
        checkOutput({tag, "_data"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        int guard;
        checks = 0; failures = 0;
        cyc = 0; latency = 3; readyMode = 0;
        stallIndex = -1; stallLeft = 0; stallAddr = '0;
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        sdram_readdata = 16'h0000; sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0; data_ready = 1'b0;
        clearStats();
        @(negedge clk);
        runCycles(3);
        checkResetOutputs("reset");
        checkOutput("const_byteenable", 32'(sdram_byteenable_n), 32'd0);
        checkOutput("const_chipselect", 32'(sdram_chipselect), 32'd1);
        reset = 1'b0;
        runCycles(2);

        $display("[TB] basic transfer 0x000100 x8, latency 3");
        startTransfer(24'h000100, 23'd8);
        runUntilDone("basic", 200);
        checkWords("basic", 16'h0100, 8);
        checkOutput("basic_first_req", 32'(firstAcc - startCycle), 32'd1);
        checkOutput("basic_first_valid", 32'(firstValid - startCycle), 32'd5);
        checkOutput("basic_done_time", 32'(doneCycle - startCycle), 32'd14);
        checkOutput("basic_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("basic_busy_at_done", 32'(doneBusy), 32'd0);
        checkOutput("basic_busy_cycles", 32'(busyCycles), 32'd13);
        checkOutput("basic_pending_le_max", 32'(maxOut <= MAX_PENDING), 32'd1);
        checkOutput("basic_credit_err", 32'(creditErr), 32'd0);
        checkOutput("basic_requests", 32'(accCount), 32'd8);

        $display("[TB] backpressure: ready 1 on / 3 off");
        readyMode = 1;
        startTransfer(24'h000100, 23'd8);
        runUntilDone("bp", 300);
        checkWords("bp", 16'h0100, 8);
        checkOutput("bp_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("bp_credit_err", 32'(creditErr), 32'd0);
        checkOutput("bp_fifo_bound", 32'(maxLvl <= FIFO_DEPTH), 32'd1);
        readyMode = 0;

        $display("[TB] long read latency exhausts pending credits");
        latency = 6;
        startTransfer(24'h000180, 23'd8);
        runUntilDone("lat6", 300);
        checkWords("lat6", 16'h0180, 8);
        checkOutput("lat6_max_pending", 32'(maxOut), 32'(MAX_PENDING));
        checkOutput("lat6_credit_err", 32'(creditErr), 32'd0);
        latency = 3;

        $display("[TB] stalled sink fills the FIFO");
        readyMode = 2;
        startTransfer(24'h000200, 23'd20);
        runCycles(40);
        checkOutput("fill_requests", 32'(accCount), 32'(FIFO_DEPTH));
        checkOutput("fill_max_level", 32'(maxLvl), 32'(FIFO_DEPTH));
        checkOutput("fill_credit_err", 32'(creditErr), 32'd0);
        readyMode = 0;
        runUntilDone("fill", 300);
        checkWords("fill", 16'h0200, 20);

        $display("[TB] waitrequest held 5 cycles on the 2nd request");
        stallIndex = 1; stallLeft = 5; stallAddr = 24'h000101;
        startTransfer(24'h000100, 23'd8);
        runUntilDone("stall", 300);
        checkOutput("stall_cycles", 32'(stallCycles), 32'd5);
        checkOutput("stall_hold_err", 32'(holdErr), 32'd0);
        checkOutput("stall_requests", 32'(accCount), 32'd8);
        checkWords("stall", 16'h0100, 8);
        stallIndex = -1; stallLeft = 0;

        $display("[TB] address wrap 0xFFFFFE x4");
        startTransfer(24'hFFFFFE, 23'd4);
        runUntilDone("wrap", 200);
        checkOutput("wrap_addr0", 32'(accAddr.size() > 0 ? accAddr[0] : 24'h123456), 32'h00FFFFFE);
        checkOutput("wrap_addr1", 32'(accAddr.size() > 1 ? accAddr[1] : 24'h123456), 32'h00FFFFFF);
        checkOutput("wrap_addr2", 32'(accAddr.size() > 2 ? accAddr[2] : 24'h123456), 32'h00000000);
        checkOutput("wrap_addr3", 32'(accAddr.size() > 3 ? accAddr[3] : 24'h123456), 32'h00000001);
        checkWords("wrap", 16'hFFFE, 4);

        $display("[TB] zero-length transfer");
        startTransfer(24'h000400, 23'd0);
        runCycles(4);
        checkOutput("zero_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("zero_done_prompt", 32'(doneCount == 1 && doneCycle - startCycle <= 2), 32'd1);
        checkOutput("zero_no_reads", 32'(readLowCycles), 32'd0);
        checkOutput("zero_no_busy", 32'(busyCycles), 32'd0);

        $display("[TB] start while busy is ignored");
        startTransfer(24'h000300, 23'd4);
        runCycles(2);
        base_addr = 24'h000500; word_count = 23'd2; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        runUntilDone("ignore", 200);
        checkOutput("ignore_requests", 32'(accCount), 32'd4);
        checkOutput("ignore_last_addr", 32'(accAddr.size() > 3 ? accAddr[3] : 24'h123456), 32'h00000303);
        checkWords("ignore", 16'h0300, 4);
        checkOutput("ignore_done_pulses", 32'(doneCount), 32'd1);

        $display("[TB] reset abort after 3 words");
        startTransfer(24'h000100, 23'd8);
        guard = 0;
        while (popCount < 3 && guard < 50) begin
            applyStimulus();
            guard++;
        end
        checkOutput("abort_reached_3", 32'(popCount), 32'd3);
        reset = 1'b1; readyMode = 2;
        applyStimulus();
        reset = 1'b0; readyMode = 0;
        checkResetOutputs("abort");
        validCycles = 0; doneCount = 0;
        runCycles(6);
        checkOutput("abort_no_valid", 32'(validCycles), 32'd0);
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        startTransfer(24'h000100, 23'd8);
        runUntilDone("restart", 200);
        checkWords("restart", 16'h0100, 8);
        checkOutput("restart_done_pulses", 32'(doneCount), 32'd1);
`ifdef ADC_SDRAM_READER_CHECKSUM_EN
        checkOutput("restart_checksum", 32'(checksum), 32'h0000081C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
